lcd_driver: RTL and testbench

LCD_DRIVER -- requirements
Module: lcd_driver

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_fifo.sv | 52 +++++
 rtl/lcd_driver.sv | 150 +++++++++++++++
 tb/tb_lcd_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD driver: FSM states,
// power-on init command ROM and the opcodes that need the long execution wait.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_W     = 9;

  localparam int INIT_LEN = 4;
  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Small synchronous FIFO buffering {RS,data} entries for the LCD driver.
// Full is judged on the registered count, so a write into a full FIFO is refused even if a pop happens that cycle.
module lcd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_wr   = wr_i && !full_o;
  assign do_rd   = rd_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointers wrap naturally; DEPTH is expected to be a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lcd_driver.sv
// Serialises LCD register stores into HD44780 8-bit write cycles, running the
// power-up wait and init command sequence after every reset.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int T_POWERUP   = 750000,
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overflow
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max_of(max_of(max_of(T_POWERUP, T_EXEC_LONG), max_of(T_EXEC, T_PULSE)),
                                max_of(T_SETUP, T_HOLD));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  lcd_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          init_idx_q;
  logic                fetched_q;
  logic [FIFO_W-1:0]   hold_q;
  logic [7:0]          data_q;
  logic                rs_q;
  logic                en_q;
  logic                on_q;
  logic                ovf_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [FIFO_W-1:0]   fifo_rdata;
  logic [2:0]          unused_fifo_count;
  logic                unused_word_bits;
  logic                cnt_zero;
  logic                init_done;

  assign unused_word_bits = ^{i_lcd_word[30:10], i_lcd_word[8]};
  assign cnt_zero  = (cnt_q == '0);
  assign init_done = (init_idx_q == 3'(INIT_LEN));

  // Pop either in IDLE or on the EXEC->IDLE edge so queued entries follow with one IDLE cycle.
  assign fifo_pop = !fifo_empty && !fetched_q &&
                    ((state_q == ST_IDLE) || ((state_q == ST_EXEC) && cnt_zero && init_done));

  lcd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_i    (i_lcd_wr),
    .wdata_i ({i_lcd_word[9], i_lcd_word[7:0]}),
    .rd_i    (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (fifo_pop) hold_q <= fifo_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_POWERUP;
      cnt_q      <= CNT_W'(T_POWERUP - 1);
      init_idx_q <= '0;
      fetched_q  <= 1'b0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      cnt_q <= cnt_zero ? cnt_q : cnt_q - 1'b1;
      if (fifo_pop) fetched_q <= 1'b1;
      case (state_q)
        ST_POWERUP: if (cnt_zero) state_q <= ST_INIT;
        ST_INIT: begin
          data_q     <= INIT_ROM[init_idx_q[1:0]];
          rs_q       <= 1'b0;
          init_idx_q <= init_idx_q + 1'b1;
          cnt_q      <= CNT_W'(T_SETUP - 1);
          state_q    <= ST_SETUP;
        end
        ST_IDLE: if (fetched_q) begin
          {rs_q, data_q} <= hold_q;
          fetched_q      <= 1'b0;
          cnt_q          <= CNT_W'(T_SETUP - 1);
          state_q        <= ST_SETUP;
        end
        ST_SETUP: if (cnt_zero) begin
          en_q    <= 1'b1;
          cnt_q   <= CNT_W'(T_PULSE - 1);
          state_q <= ST_PULSE;
        end
        ST_PULSE: if (cnt_zero) begin
          en_q    <= 1'b0;
          cnt_q   <= CNT_W'(T_HOLD - 1);
          state_q <= ST_HOLD;
        end
        ST_HOLD: if (cnt_zero) begin
          cnt_q   <= is_long_cmd(rs_q, data_q) ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
          state_q <= ST_EXEC;
        end
        ST_EXEC: if (cnt_zero) state_q <= init_done ? ST_IDLE : ST_INIT;
        default: begin
          en_q    <= 1'b0;
          state_q <= ST_POWERUP;
        end
      endcase
    end
  end

  // Backlight follows every store, even ones the full FIFO refuses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (i_lcd_wr) on_q <= i_lcd_word[31];
      if (i_lcd_wr && fifo_full) ovf_q <= 1'b1;
    end
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_overflow = ovf_q;
  assign o_busy     = !((state_q == ST_IDLE) && fifo_empty && !fetched_q);

endmodule

// File: tb/tb_lcd_driver.sv
// Randomised bench for lcd_driver: observed EN pulses are matched against a
// queue of expected HD44780 writes with timing derived from the cycle rules.
module tb_lcd_driver;

  localparam int TP = 10;
  localparam int TS = 2;
  localparam int TW = 4;
  localparam int TH = 2;
  localparam int TE = 8;
  localparam int TL = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic [31:0] word = '0;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_busy;
  logic        o_overflow;

  lcd_driver #(
    .T_POWERUP   (TP),
    .T_SETUP     (TS),
    .T_PULSE     (TW),
    .T_HOLD      (TH),
    .T_EXEC      (TE),
    .T_EXEC_LONG (TL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_lcd_wr   (wr),
    .i_lcd_word (word),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wcyc;
    int         lat;
  } ent_t;

  ent_t exp_q[$];
  logic exp_ovf = 1'b0;

  // HD44780 clear (0x01) and return-home (0x02/0x03) take the long wait.
  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? TL : TE;
  endfunction

  logic       prev_en = 1'b0;
  bit         have_prev = 1'b0;
  int         rise_c, prev_fall, prev_exec, cur_exec;
  logic [8:0] cur;

  task automatic mon();
    ent_t e;
    if (reset) begin
      prev_en   = 1'b0;
      have_prev = 1'b0;
      return;
    end
    if (o_lcd_en && !prev_en) begin
      rise_c = cyc;
      if (exp_q.size() == 0) begin
        chk("pending_entries_at_pulse", exp_q.size(), 1);
        cur_exec = TE;
      end else begin
        e = exp_q.pop_front();
        chk("pulse_rs_data", {o_lcd_rs, o_lcd_data}, {e.rs, e.data});
        if (e.lat >= 0) chk("write_to_en_latency", cyc - e.wcyc, e.lat);
        if (have_prev && e.wcyc < prev_fall)
          chk("en_low_gap", cyc - prev_fall, TH + prev_exec + 1 + TS);
        cur_exec = exec_len(e.rs, e.data);
      end
      cur = {o_lcd_rs, o_lcd_data};
    end else if (o_lcd_en) begin
      chk("stable_in_pulse", {o_lcd_rs, o_lcd_data}, cur);
    end else if (have_prev && (cyc - prev_fall) < TH) begin
      chk("stable_in_hold", {o_lcd_rs, o_lcd_data}, cur);
    end
    if (!o_lcd_en && prev_en) begin
      chk("pulse_width", cyc - rise_c, TW);
      prev_fall = cyc;
      prev_exec = cur_exec;
      have_prev = 1'b1;
    end
    prev_en = o_lcd_en;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic push_ent(input logic rs, input logic [7:0] d, input int wcyc, input int lat);
    ent_t e;
    e.rs = rs; e.data = d; e.wcyc = wcyc; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic do_write(input logic [31:0] w_word, input int lat, output int wcyc);
    wr   = 1'b1;
    word = w_word;
    wcyc = cyc + 1;
    if (exp_q.size() < 4) push_ent(w_word[9], w_word[7:0], wcyc, lat);
    else exp_ovf = 1'b1;
    tick();
    chk("backlight", o_lcd_on, w_word[31]);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && o_busy; i++) tick();
    chk("idle_reached", o_busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("overflow_flag", o_overflow, exp_ovf);
  endtask

  task automatic wait_en(input int budget);
    for (int i = 0; i < budget && !o_lcd_en; i++) tick();
    chk("en_seen", o_lcd_en, 1);
  endtask

  task automatic reset_checks();
    chk("rst_en", o_lcd_en, 0);
    chk("rst_data", o_lcd_data, 8'h00);
    chk("rst_rs", o_lcd_rs, 0);
    chk("rst_rw", o_lcd_rw, 0);
    chk("rst_on", o_lcd_on, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_busy", o_busy, 1);
  endtask

  task automatic release_reset();
    int rel;
    repeat (2) tick();
    reset = 1'b0;
    rel = cyc;
    push_ent(1'b0, 8'h38, rel, TP + 1 + TS);
    push_ent(1'b0, 8'h0C, -1, -1);
    push_ent(1'b0, 8'h01, -1, -1);
    push_ent(1'b0, 8'h06, -1, -1);
    wait_idle(300);
  endtask

  initial begin
    int w, w2;
    logic [31:0] rw;
    int n;

    reset = 1'b1;
    #1;
    reset_checks();
    release_reset();

    // Single write with backlight: latency, presented data, busy release.
    do_write(32'h8000_0241, TS + 2, w);
    wr = 1'b0;
    tick();
    tick();
    chk("data_two_edges_later", {o_lcd_rs, o_lcd_data}, 9'h141);
    for (int i = 0; i < 100 && o_busy; i++) tick();
    chk("busy_clear_cycle", cyc - w, 2 + TS + TW + TH + TE);
    chk("on_held", o_lcd_on, 1);

    // Five writes while a pulse is active: four kept, fifth dropped.
    do_write(32'h8000_0241, TS + 2, w);
    wr = 1'b0;
    wait_en(50);
    for (int i = 0; i < 5; i++) do_write(32'h0000_0200 + 32'(i), -1, w2);
    wr = 1'b0;
    tick();
    chk("overflow_set", o_overflow, 1);
    wait_idle(400);

    // Clear followed by 'A': long then normal execution wait.
    do_write(32'h0000_0001, TS + 2, w);
    do_write(32'h0000_0241, -1, w2);
    wr = 1'b0;
    wait_idle(200);
    chk("exec_after_A", cyc - prev_fall, TH + TE);

    // Randomised bursts of up to four stores from idle.
    for (int b = 0; b < 30; b++) begin
      repeat ($urandom_range(0, 3)) tick();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        rw = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          rw[9]   = 1'b0;
          rw[7:0] = 8'($urandom_range(1, 3));
        end
        do_write(rw, (k == 0) ? TS + 2 : -1, w);
      end
      wr = 1'b0;
      wait_idle(400);
    end

    // Reset in the middle of a pulse, with entries still queued.
    do_write(32'h8000_0241, TS + 2, w);
    wr = 1'b0;
    wait_en(50);
    do_write(32'h8000_0242, -1, w2);
    do_write(32'h8000_0243, -1, w2);
    wr = 1'b0;
    chk("en_before_reset", o_lcd_en, 1);
    #2 reset = 1'b1;
    #1;
    reset_checks();
    exp_q.delete();
    exp_ovf = 1'b0;
    release_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
